// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined).
// rx_in is synchronised to clk_in; results are reported with registered one-cycle pulses.
module uart_rx (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clk_baud,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        even_parity = ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t     state_r, state_n;
    logic       sync1_r;
    logic       rx_s;
    logic [3:0] tick_cnt_r, tick_cnt_n;
    logic [2:0] bit_idx_r, bit_idx_n;
    logic [7:0] shift_r, shift_n;
    logic [7:0] data_n;
    logic       done_n, ferr_n, perr_n, busy_n;
`ifdef UART_RX_PARITY_EN
    logic       mism_r, mism_n;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            rx_s    <= sync1_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            data_out   <= 8'd0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            mism_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_n;
            tick_cnt_r <= tick_cnt_n;
            bit_idx_r  <= bit_idx_n;
            shift_r    <= shift_n;
            data_out   <= data_n;
            rx_done    <= done_n;
            frame_err  <= ferr_n;
            parity_err <= perr_n;
            busy       <= busy_n;
`ifdef UART_RX_PARITY_EN
            mism_r     <= mism_n;
`endif
        end
    end

    // Next-state and next-output logic; only IDLE reacts between baud ticks.
    always_comb begin
        state_n    = state_r;
        tick_cnt_n = tick_cnt_r;
        bit_idx_n  = bit_idx_r;
        shift_n    = shift_r;
        data_n     = data_out;
        done_n     = 1'b0;
        ferr_n     = 1'b0;
        perr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
        mism_n     = mism_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n    = ST_START;
                    tick_cnt_n = 4'd0;
`ifdef UART_RX_PARITY_EN
                    mism_n     = 1'b0;
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_baud) begin
                    if (tick_cnt_r == 4'd7) begin
                        tick_cnt_n = 4'd0;
                        bit_idx_n  = 3'd0;
                        // A start bit that is already high again mid-bit was a glitch.
                        if (!rx_s) begin
                            state_n = ST_DATA;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + 4'd1;
                    end
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (clk_baud) begin
                    tick_cnt_n = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == 4'd15) begin
                        shift_n = {rx_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_n = 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_n   = ST_PARITY;
`else
                            state_n   = ST_STOP;
`endif
                        end else begin
                            bit_idx_n = bit_idx_r + 3'd1;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_baud) begin
                    tick_cnt_n = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == 4'd15) begin
                        mism_n  = rx_s ^ even_parity(shift_r);
                        state_n = ST_STOP;
                    end else begin
                        state_n = ST_PARITY;
                    end
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (clk_baud) begin
                    tick_cnt_n = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == 4'd15) begin
                        data_n     = shift_r;
                        state_n    = ST_IDLE;
                        tick_cnt_n = 4'd0;
                        if (rx_s) begin
                            done_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_n = mism_r;
`endif
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end else begin
                        state_n = ST_STOP;
                    end
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                tick_cnt_n = 4'd0;
                bit_idx_n  = 3'd0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: frames are built bit by bit and the
// expected byte/error outcome of each frame is queued and matched against the pulses.
module tb_uart_rx;

    logic       clk_in   = 1'b0;
    logic       reset    = 1'b1;
    logic       clk_baud = 1'b0;
    logic       rx_in    = 1'b1;
    logic [7:0] data_out;
    logic       rx_done, frame_err, parity_err, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int div_cnt  = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;

    uart_rx dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .clk_baud   (clk_baud),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    // Baud tick: one clk_in cycle in every six, changed on the falling edge.
    always @(negedge clk_in) begin
        div_cnt  = (div_cnt == 5) ? 0 : div_cnt + 1;
        clk_baud = (div_cnt == 0);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every result pulse must match the oldest outstanding frame expectation.
    always @(negedge clk_in) begin
        if (!reset && (rx_done || frame_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", 32'({rx_done, frame_err, parity_err}), 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                check_val("data_out",   32'(data_out),   32'(mon_ev.data));
                check_val("rx_done",    32'(rx_done),    32'(!mon_ev.ferr));
                check_val("frame_err",  32'(frame_err),  32'(mon_ev.ferr));
                check_val("parity_err", 32'(parity_err), 32'(mon_ev.perr));
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk_in); while (clk_baud !== 1'b1);
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) wait_tick();
    endtask

    // One serial bit lasting 16 ticks, optionally checking busy at mid-bit.
    task automatic send_full_bit(input logic b, input bit chk_busy);
        send_bit(b, 8);
        if (chk_busy) begin
            @(negedge clk_in);
            check_val("busy_mid_frame", 32'(busy), 32'd1);
        end
        send_bit(b, 8);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input logic par_bit,
                              input bit chk_busy);
        ev_t ev;
        ev.data = d;
        ev.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
        ev.perr = stop_ok && (par_bit != (^d));
`else
        ev.perr = 1'b0;
`endif
        exp_q.push_back(ev);
        send_full_bit(1'b0, chk_busy);
        for (int i = 0; i < 8; i++) send_full_bit(d[i], chk_busy);
`ifdef UART_RX_PARITY_EN
        send_full_bit(par_bit, chk_busy);
`endif
        if (stop_ok) begin
            send_bit(1'b1, 16);
        end else begin
            // Low through the sampling tick, then released so no break follows.
            send_bit(1'b0, 8);
            send_bit(1'b1, 8);
        end
        check_val("frame_consumed", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        bit         rok;
        logic       rpar;

        repeat (4) @(negedge clk_in);
        check_val("rst_data_out",   32'(data_out),   32'h00);
        check_val("rst_rx_done",    32'(rx_done),    32'd0);
        check_val("rst_frame_err",  32'(frame_err),  32'd0);
        check_val("rst_parity_err", 32'(parity_err), 32'd0);
        check_val("rst_busy",       32'(busy),       32'd0);
        reset = 1'b0;
        repeat (4) wait_tick();

        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
        @(negedge clk_in);
        check_val("busy_after_frame", 32'(busy), 32'd0);
        check_val("a5_data_hold",     32'(data_out), 32'hA5);

        // Start glitch of four ticks.
        send_bit(1'b0, 4);
        @(negedge clk_in);
        check_val("glitch_busy_high", 32'(busy), 32'd1);
        send_bit(1'b1, 8);
        @(negedge clk_in);
        check_val("glitch_busy_low", 32'(busy), 32'd0);
        check_val("glitch_data_hold", 32'(data_out), 32'hA5);
        send_bit(1'b1, 8);

        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        check_val("ferr_data_hold", 32'(data_out), 32'h3C);
        send_bit(1'b1, 4);

        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 4);

        // Abort 0x55 midway through data bit 3.
        send_full_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_full_bit(1'b1 ^ i[0], 1'b0);
        send_bit(1'b0, 6);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check_val("abort_data_out",  32'(data_out), 32'h00);
        check_val("abort_busy",      32'(busy),     32'd0);
        check_val("abort_rx_done",   32'(rx_done),  32'd0);
        check_val("abort_frame_err", 32'(frame_err), 32'd0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (3) wait_tick();
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
        send_bit(1'b1, 2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 2);
`endif

        for (int f = 0; f < 24; f++) begin
            rd   = 8'($urandom);
            rok  = ($urandom_range(0, 7) != 0);
            rpar = (^rd) ^ ($urandom_range(0, 3) == 0);
            send_frame(rd, rok, rpar, 1'b0);
            send_bit(1'b1, $urandom_range(0, 2));
        end

        send_bit(1'b1, 20);
        check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("final_busy",        32'(busy),         32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
